// File: rtl/rf_write_queue_pkg.sv
// Shared defaults and helpers for the register-file write queue.
//   DEF_DATA_W / DEF_ADDR_W : default data and register-address widths
//   ptr_w(depth)            : queue pointer width, log2(depth)
package rf_write_queue_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 6;
    localparam int unsigned DEF_DEPTH  = 4;

    // Pointer width for a power-of-two queue depth (depth >= 2).
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rf_wq_match.sv
// Youngest-first priority matcher over the queued entries.
//   ent_addr/ent_data : circular entry storage
//   head/count        : occupied region, head is oldest
//   q_addr            : lookup address
//   hit/data          : youngest matching entry, data is 0 when no hit
module rf_wq_match
    import rf_write_queue_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
    input  logic [ptr_w(DEPTH)-1:0]      head,
    input  logic [ptr_w(DEPTH):0]        count,
    input  logic [ADDR_W-1:0]            q_addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest; a later match overrides, so the youngest wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (ent_addr[idx] == q_addr)) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/rf_write_queue.sv
// Register-file write queue: buffers writeback results in order, drains one
// per cycle onto the regfile write port and forwards pending data to readers.
//   clk, reset (sync, active-low)
//   in_valid/in_ready/in_addr/in_data : writeback request handshake
//   hold  : suppress popping this cycle
//   flush : drop all queued and staged writes
//   rf_we/rf_wa/rf_wd : registered regfile write port
//   q_addr1/2 -> q_hit1/2, q_data1/2 : combinational pending-write lookup
//   count : queued entries, excluding the staged one
module rf_write_queue
    import rf_write_queue_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    hold,
    input  logic                    flush,
    output logic                    rf_we,
    output logic [ADDR_W-1:0]       rf_wa,
    output logic [DATA_W-1:0]       rf_wd,
    input  logic [ADDR_W-1:0]       q_addr1,
    output logic                    q_hit1,
    output logic [DATA_W-1:0]       q_data1,
    input  logic [ADDR_W-1:0]       q_addr2,
    output logic                    q_hit2,
    output logic [DATA_W-1:0]       q_data2,
    output logic [ptr_w(DEPTH):0]   count
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [PTR_W-1:0]             head;
    logic [PTR_W-1:0]             tail;

    logic push;
    logic pop;

    // Full blocks acceptance even if a pop happens this cycle.
    assign in_ready = (count != CNT_W'(DEPTH)) && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && !hold && !flush;

    // Entry storage; validity is defined by head/count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= in_addr;
            ent_data[tail] <= in_data;
        end
    end

    // Pointers, occupancy and the staged regfile write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else if (flush) begin
            head  <= tail;
            count <= '0;
            rf_we <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                rf_we <= 1'b1;
                rf_wa <= ent_addr[head];
                rf_wd <= ent_data[head];
                head  <= head + PTR_W'(1);
            end else begin
                rf_we <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    logic              m_hit1;
    logic              m_hit2;
    logic [DATA_W-1:0] m_data1;
    logic [DATA_W-1:0] m_data2;

    rf_wq_match #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_match1 (
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .head     (head),
        .count    (count),
        .q_addr   (q_addr1),
        .hit      (m_hit1),
        .data     (m_data1)
    );

    rf_wq_match #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_match2 (
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .head     (head),
        .count    (count),
        .q_addr   (q_addr2),
        .hit      (m_hit2),
        .data     (m_data2)
    );

    // Queue entries are younger than the staged write, so they take priority.
    logic stg_hit1;
    logic stg_hit2;

    assign stg_hit1 = rf_we && (rf_wa == q_addr1);
    assign stg_hit2 = rf_we && (rf_wa == q_addr2);

    assign q_hit1  = m_hit1 || stg_hit1;
    assign q_data1 = m_hit1 ? m_data1 : (stg_hit1 ? rf_wd : '0);
    assign q_hit2  = m_hit2 || stg_hit2;
    assign q_data2 = m_hit2 ? m_data2 : (stg_hit2 ? rf_wd : '0);

endmodule

// File: tb/tb_rf_write_queue.sv
module tb_rf_write_queue;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              hold;
    logic              flush;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic [ADDR_W-1:0] q_addr1;
    logic              q_hit1;
    logic [DATA_W-1:0] q_data1;
    logic [ADDR_W-1:0] q_addr2;
    logic              q_hit2;
    logic [DATA_W-1:0] q_data2;
    logic [2:0]        count;

    int n_checks;
    int n_pass;

    rf_write_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .hold     (hold),
        .flush    (flush),
        .rf_we    (rf_we),
        .rf_wa    (rf_wa),
        .rf_wd    (rf_wd),
        .q_addr1  (q_addr1),
        .q_hit1   (q_hit1),
        .q_data1  (q_data1),
        .q_addr2  (q_addr2),
        .q_hit2   (q_hit2),
        .q_data2  (q_data2),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int a, input int d);
        in_valid = 1'b1;
        in_addr  = ADDR_W'(a);
        in_data  = DATA_W'(d);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        hold     = 1'b0;
        flush    = 1'b0;
        q_addr1  = '0;
        q_addr2  = '0;

        // Reset then idle
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst_we",    32'(rf_we), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ready", 32'(in_ready), 1);
        check("rst_hit1",  32'(q_hit1), 0);
        check("rst_data1", q_data1, 0);

        // Single write addr=1 data=7
        q_addr1 = 6'd1;
        push_one(1, 7);
        check("sw_count",  32'(count), 1);
        check("sw_hit_q",  32'(q_hit1), 1);
        check("sw_data_q", q_data1, 7);
        check("sw_we0",    32'(rf_we), 0);
        tick();
        check("sw_we",     32'(rf_we), 1);
        check("sw_wa",     32'(rf_wa), 1);
        check("sw_wd",     rf_wd, 7);
        check("sw_count0", 32'(count), 0);
        check("sw_hit_s",  32'(q_hit1), 1);
        check("sw_data_s", q_data1, 7);
        tick();
        check("sw_we_off", 32'(rf_we), 0);
        check("sw_hit_off", 32'(q_hit1), 0);

        // Fill with hold=1
        hold = 1'b1;
        push_one(2, 10);
        push_one(3, 11);
        push_one(2, 12);
        push_one(5, 13);
        check("fill_count", 32'(count), 4);
        check("fill_ready", 32'(in_ready), 0);
        check("fill_we",    32'(rf_we), 0);
        push_one(9, 99);
        check("fill_5th",   32'(count), 4);
        q_addr1 = 6'd2;
        q_addr2 = 6'd5;
        #1;
        check("fill_hit1",  32'(q_hit1), 1);
        check("fill_dup",   q_data1, 12);
        check("fill_data2", q_data2, 13);
        q_addr2 = 6'd3;
        #1;
        check("fill_data3", q_data2, 11);
        q_addr2 = 6'd9;
        #1;
        check("fill_miss",  32'(q_hit2), 0);
        hold = 1'b0;
        tick();
        check("dr0_we", 32'(rf_we), 1);
        check("dr0_wa", 32'(rf_wa), 2);
        check("dr0_wd", rf_wd, 10);
        check("dr0_cnt", 32'(count), 3);
        tick();
        check("dr1_wa", 32'(rf_wa), 3);
        check("dr1_wd", rf_wd, 11);
        tick();
        check("dr2_wa", 32'(rf_wa), 2);
        check("dr2_wd", rf_wd, 12);
        tick();
        check("dr3_wa", 32'(rf_wa), 5);
        check("dr3_wd", rf_wd, 13);
        check("dr3_we", 32'(rf_we), 1);
        check("dr3_cnt", 32'(count), 0);
        tick();
        check("dr_end_we", 32'(rf_we), 0);

        // Steady stream of 8 writes
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_addr  = ADDR_W'(16 + k);
            in_data  = DATA_W'(100 + k);
            tick();
            check("st_count", 32'(count), 1);
            if (k > 0) begin
                check("st_we", 32'(rf_we), 1);
                check("st_wa", 32'(rf_wa), 32'(16 + k - 1));
                check("st_wd", rf_wd, 32'(100 + k - 1));
            end
        end
        in_valid = 1'b0;
        tick();
        check("st_last_wa", 32'(rf_wa), 23);
        check("st_last_wd", rf_wd, 107);
        check("st_cnt0",    32'(count), 0);
        tick();
        check("st_idle_we", 32'(rf_we), 0);

        // Flush mid-drain: 3 queued + 1 staged
        hold = 1'b1;
        push_one(30, 200);
        push_one(31, 201);
        push_one(32, 202);
        push_one(33, 203);
        hold = 1'b0;
        tick();
        check("fl_pre_cnt", 32'(count), 3);
        check("fl_pre_we",  32'(rf_we), 1);
        flush    = 1'b1;
        hold     = 1'b1;
        in_valid = 1'b1;
        in_addr  = 6'd40;
        in_data  = 32'd400;
        #1;
        check("fl_ready", 32'(in_ready), 0);
        tick();
        flush    = 1'b0;
        hold     = 1'b0;
        in_valid = 1'b0;
        q_addr1  = 6'd31;
        q_addr2  = 6'd30;
        #1;
        check("fl_cnt",   32'(count), 0);
        check("fl_we",    32'(rf_we), 0);
        check("fl_hit1",  32'(q_hit1), 0);
        check("fl_hit2",  32'(q_hit2), 0);
        check("fl_wa_hold", 32'(rf_wa), 30);
        check("fl_ready_back", 32'(in_ready), 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("fl_quiet_we",  32'(rf_we), 0);
            check("fl_quiet_cnt", 32'(count), 0);
        end

        // Reset mid-operation: 2 queued
        hold = 1'b1;
        push_one(40, 300);
        push_one(41, 301);
        check("rm_pre_cnt", 32'(count), 2);
        reset = 1'b0;
        tick();
        reset   = 1'b1;
        hold    = 1'b0;
        q_addr1 = 6'd40;
        q_addr2 = 6'd41;
        #1;
        check("rm_cnt",  32'(count), 0);
        check("rm_we",   32'(rf_we), 0);
        check("rm_wa",   32'(rf_wa), 0);
        check("rm_wd",   rf_wd, 0);
        check("rm_hit1", 32'(q_hit1), 0);
        check("rm_hit2", 32'(q_hit2), 0);
        check("rm_data1", q_data1, 0);
        tick();
        check("rm_after_we", 32'(rf_we), 0);
        check("rm_after_cnt", 32'(count), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_write_queue.md
Name: rf_write_queue

Overview:
Write-side front end for the register file. Accepts writeback results over a valid/ready handshake and buffers them in order in a small circular queue. Drains one entry per cycle onto the regfile write port (we/wa/wd). Provides a combinational lookup on two read addresses so the read side can forward pending data that has not reached the regfile yet.

Parameters:
DATA_W, 32, width of write data and forwarded data
ADDR_W, 6, register address width
DEPTH, 4, queue entries; power of 2, at least 2

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low; 0 at a rising edge resets all state
in_valid  in  1  producer has a write request
in_ready  out  1  queue can accept a request this cycle
in_addr  in  ADDR_W  destination register
in_data  in  DATA_W  value to write
hold  in  1  1 = do not pop this cycle; entries stay queued
flush  in  1  discard all queued and staged writes
rf_we  out  1  regfile write enable (registered)
rf_wa  out  ADDR_W  regfile write address (registered)
rf_wd  out  DATA_W  regfile write data (registered)
q_addr1  in  ADDR_W  lookup address, port 1
q_addr2  in  ADDR_W  lookup address, port 2
q_hit1  out  1  pending write to q_addr1 exists
q_data1  out  DATA_W  youngest pending data for q_addr1; 0 when no hit
q_hit2  out  1  as q_hit1, for port 2
q_data2  out  DATA_W  as q_data1, for port 2
count  out  log2(DEPTH)+1  number of queued entries, excluding the staged one

Behaviour:
- Reset (reset=0 at an edge):
  - head, tail and count go to 0; all entries become invalid.
  - rf_we, rf_wa and rf_wd go to 0.
  - q_hit1/2 = 0 and q_data1/2 = 0 in the following cycle.
  - Reset mid-drain drops every pending write; nothing reaches the regfile.
- Handshake:
  - in_ready = (count != DEPTH) && !flush, combinational.
  - A request is accepted at an edge where in_valid && in_ready; the entry is written at tail and tail increments modulo DEPTH.
  - in_ready must not depend on in_valid.
  - When the queue is full, in_ready=0 even if a pop happens in the same cycle; there is no same-cycle refill of the last slot.
- Drain:
  - At each edge where count>0 && !hold && !flush: the head entry moves into the rf_* registers, rf_we=1 for the next cycle, head increments modulo DEPTH.
  - Otherwise rf_we=0 in the next cycle; rf_wa and rf_wd hold their values.
- Latency: a request accepted at edge E into an empty queue with hold=0 pops at E+1, drives rf_we=1 in the cycle after E+1, and is written into the regfile at E+2. Sustained throughput is one write per cycle.
- Simultaneous accept and pop: count is unchanged. With count=0, the accepted entry cannot pop at the same edge; there is no bypass.
- Order: writes leave in acceptance order. Duplicate addresses are kept as separate entries and are not merged.
- flush:
  - At the edge, count goes to 0, head is set to tail, and rf_we goes to 0.
  - Any request presented in that cycle is not accepted, because in_ready is 0.
  - flush takes priority over hold.
- Lookup (combinational on q_addr and current state):
  - Search order is youngest queued entry (tail-1) back to head, then the staged rf_* entry if rf_we=1.
  - The first match sets hit=1 and data to that entry's data.
  - The staged entry counts as pending because the regfile commits it only at the coming edge.
  - Entries being accepted in the current cycle are not visible until the next cycle.
- Width rules: pointers are log2(DEPTH) bits and wrap naturally. count has one extra bit so that full (count=DEPTH) is distinct from empty.

Decomposition:
- Shared defines (defines.v): DATA_W and ADDR_W defaults, and the function that computes pointer width as log2(DEPTH).
- One natural sub-module, rf_wq_match: a DEPTH-way youngest-first priority matcher. It takes the entry arrays plus head/count and returns hit/data. Instantiate it twice, once per lookup port.

Test Plan:
- Reset then idle: hold reset=0 for 2 edges, then release → rf_we=0, count=0, in_ready=1, q_hit1=0, q_data1=0.
- Single write: accept addr=1, data=7 at edge E → q_hit1=1 and q_data1=7 for q_addr1=1 from E until the write commits; rf_we=1, rf_wa=1, rf_wd=7 in the cycle after E+1; rf_we=0 afterwards with no further traffic.
- Fill with hold=1: accept 4 writes (addr=2/3/2/5, data=10/11/12/13) → count=4, in_ready=0, a 5th request is not accepted, q_addr1=2 gives q_data1=12.
  - Release hold → rf_wa sequence 2,3,2,5 with data 10,11,12,13 on consecutive cycles.
- Steady stream: in_valid=1 every cycle for 8 writes, hold=0 → one rf_we per cycle, count never exceeds 1, order preserved.
- Flush mid-drain: 3 entries queued and one staged, assert flush for 1 cycle → count=0 and rf_we=0 next cycle, q_hit1=q_hit2=0, no further regfile writes.
- Reset mid-operation: 2 entries queued, reset=0 for one edge → same as flush, and rf_wa=0, rf_wd=0.
